// File: rtl/cal_feed_if.sv
// cal_feed_if: output stream bundle of cal_feed.
// Carries the H row stream and the alpha column stream. The alpha stream has
// a ready back-channel. The H row stream has none: it shares the alpha
// handshake and stays constant across the A beats of a row.
interface cal_feed_if #(
   parameter int J = 14
);
   logic [J-1:0]   H_row;
   logic           H_row_tvalid;
   logic           H_row_tlast;
   logic [J*8-1:0] alpha_u_col;
   logic           alpha_u_col_tvalid;
   logic           alpha_u_col_tlast;
   logic           alpha_u_col_tready;

   modport master (
      output H_row, H_row_tvalid, H_row_tlast,
      output alpha_u_col, alpha_u_col_tvalid, alpha_u_col_tlast,
      input  alpha_u_col_tready
   );

   modport slave (
      input  H_row, H_row_tvalid, H_row_tlast,
      input  alpha_u_col, alpha_u_col_tvalid, alpha_u_col_tlast,
      output alpha_u_col_tready
   );
endinterface

// File: rtl/cal_feed.sv
// cal_feed: streams a stored H matrix (I rows x J bits) together with A alpha
// beats per row (J lanes of unsigned Q0.8) to a downstream consumer.
// The tables are loaded through the cfg port while the block is idle.
// Optional feature macro: CAL_FEED_SKIP_EMPTY_EN. When it is defined, rows
// whose H entry is all-zero are skipped entirely.
module cal_feed #(
   parameter int J = 14,
   parameter int I = 7,
   parameter int A = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cfg_we,
   input  logic                  cfg_sel,
   input  logic [$clog2(I*A):0]  cfg_addr,
   input  logic [J*8-1:0]        cfg_wdata,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   cal_feed_if.master            s
);

   localparam int AW = $clog2(I*A) + 1;
   localparam int RW = (I > 1) ? $clog2(I) : 1;
   localparam int BW = (A > 1) ? $clog2(A) : 1;
   localparam int IW = (I*A > 1) ? $clog2(I*A) : 1;

   typedef enum logic [1:0] {IDLE, SEND, FIN} state_t;

   state_t         state;
   logic [RW-1:0]  row;
   logic [BW-1:0]  beat;
   logic [J-1:0]   h_row_q;
   logic [J*8-1:0] alpha_q;
   logic           vld_q;
   logic           h_last_q;
   logic           a_last_q;

   logic [J-1:0]   h_tab [I];
   logic [J*8-1:0] a_tab [I*A];

   logic           h_ok;
   logic           a_ok;
   logic           last_beat;
   logic           frame_end;
   logic [RW-1:0]  first_row;
   logic [RW-1:0]  last_row;
   logic [RW-1:0]  nxt_row;
   logic [BW-1:0]  nxt_beat;
`ifdef CAL_FEED_SKIP_EMPTY_EN
   logic           any_row;
`endif

   // Flat alpha table index for a (row, beat) pair.
   function automatic logic [IW-1:0] a_index(input logic [RW-1:0] r,
                                             input logic [BW-1:0] b);
      return IW'(r) * IW'(A) + IW'(b);
   endfunction

   assign busy = (state != IDLE);
   assign h_ok = (cfg_addr < AW'(I));
   assign a_ok = (cfg_addr < AW'(I*A));

   assign s.H_row              = h_row_q;
   assign s.H_row_tvalid       = vld_q;
   assign s.H_row_tlast        = h_last_q;
   assign s.alpha_u_col        = alpha_q;
   assign s.alpha_u_col_tvalid = vld_q;
   assign s.alpha_u_col_tlast  = a_last_q;

   // Table storage. It is not reset, so its contents survive rst_n.
   // Writes are locked out while a frame is running.
   always_ff @(posedge clk) begin
      if (cfg_we && !busy) begin
         if (!cfg_sel && h_ok)
            h_tab[cfg_addr[RW-1:0]] <= cfg_wdata[J-1:0];
         if (cfg_sel && a_ok)
            a_tab[cfg_addr[IW-1:0]] <= cfg_wdata;
      end
   end

   // Work out the next (row, beat) position and the first/last rows of the frame.
   always_comb begin
      last_beat = (beat == BW'(A-1));
      nxt_beat  = last_beat ? '0 : beat + BW'(1);
`ifdef CAL_FEED_SKIP_EMPTY_EN
      first_row = '0;
      last_row  = '0;
      any_row   = 1'b0;
      nxt_row   = row;
      for (int k = I-1; k >= 0; k--) begin
         if (h_tab[k] != '0) begin
            first_row = RW'(k);
            any_row   = 1'b1;
         end
      end
      for (int k = 0; k < I; k++) begin
         if (h_tab[k] != '0)
            last_row = RW'(k);
      end
      if (last_beat) begin
         for (int k = I-1; k >= 0; k--) begin
            if (h_tab[k] != '0 && RW'(k) > row)
               nxt_row = RW'(k);
         end
      end
`else
      first_row = '0;
      last_row  = RW'(I-1);
      nxt_row   = last_beat ? row + RW'(1) : row;
`endif
      frame_end = last_beat && (row == last_row);
   end

   // Frame sequencer. All stream outputs are registered and are cleared at once
   // by rst_n.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         done     <= 1'b0;
         row      <= '0;
         beat     <= '0;
         h_row_q  <= '0;
         alpha_q  <= '0;
         vld_q    <= 1'b0;
         h_last_q <= 1'b0;
         a_last_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  state <= SEND;
                  row   <= first_row;
                  beat  <= '0;
`ifdef CAL_FEED_SKIP_EMPTY_EN
                  if (any_row) begin
`else
                  begin
`endif
                     h_row_q  <= h_tab[first_row];
                     alpha_q  <= a_tab[a_index(first_row, '0)];
                     vld_q    <= 1'b1;
                     h_last_q <= (first_row == last_row);
                     a_last_q <= (A == 1);
                  end
               end
            end
            SEND: begin
`ifdef CAL_FEED_SKIP_EMPTY_EN
               // An empty frame emits no beats: it goes straight to FIN.
               if (!vld_q) begin
                  state <= FIN;
                  done  <= 1'b1;
               end else
`endif
               if (vld_q && s.alpha_u_col_tready) begin
                  if (frame_end) begin
                     state    <= FIN;
                     done     <= 1'b1;
                     row      <= '0;
                     beat     <= '0;
                     h_row_q  <= '0;
                     alpha_q  <= '0;
                     vld_q    <= 1'b0;
                     h_last_q <= 1'b0;
                     a_last_q <= 1'b0;
                  end else begin
                     row      <= nxt_row;
                     beat     <= nxt_beat;
                     h_row_q  <= h_tab[nxt_row];
                     alpha_q  <= a_tab[a_index(nxt_row, nxt_beat)];
                     h_last_q <= (nxt_row == last_row);
                     a_last_q <= (nxt_beat == BW'(A-1));
                  end
               end
            end
            FIN: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cal_feed.sv
// tb_cal_feed: scoreboard bench for cal_feed. Expected beats are queued when
// a frame is started, and a monitor compares every valid output cycle against
// the head of the queue.
module tb_cal_feed;

   localparam int J  = 14;
   localparam int I  = 7;
   localparam int A  = 2;
   localparam int AW = $clog2(I*A) + 1;
`ifdef CAL_FEED_SKIP_EMPTY_EN
   localparam bit SKIP = 1'b1;
`else
   localparam bit SKIP = 1'b0;
`endif

   typedef struct packed {
      logic [J-1:0]   h;
      logic [J*8-1:0] a;
      logic           hl;
      logic           al;
   } beat_t;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           cfg_we;
   logic           cfg_sel;
   logic [AW-1:0]  cfg_addr;
   logic [J*8-1:0] cfg_wdata;
   logic           start;
   logic           busy;
   logic           done;

   cal_feed_if #(.J(J)) bus ();

   cal_feed #(.J(J), .I(I), .A(A)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cfg_we    (cfg_we),
      .cfg_sel   (cfg_sel),
      .cfg_addr  (cfg_addr),
      .cfg_wdata (cfg_wdata),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .s         (bus)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;

   logic [J-1:0]   h_m [I];
   logic [J*8-1:0] a_m [I*A];
   beat_t          q [$];

   int acc_cnt, vcnt, done_cnt, first_vcyc, last_acc_cyc, done_cyc, start_cyc;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chki(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic cfg_write(input logic sel, input int addr, input logic [J*8-1:0] data);
      @(posedge clk); #1;
      cfg_we = 1'b1; cfg_sel = sel; cfg_addr = AW'(addr); cfg_wdata = data;
      @(posedge clk); #1;
      cfg_we = 1'b0;
   endtask

   task automatic check_idle_zero(input string tag);
      chk({tag, "_busy"},   128'(busy), 128'(0));
      chk({tag, "_done"},   128'(done), 128'(0));
      chk({tag, "_hvld"},   128'(bus.H_row_tvalid), 128'(0));
      chk({tag, "_avld"},   128'(bus.alpha_u_col_tvalid), 128'(0));
      chk({tag, "_hlast"},  128'(bus.H_row_tlast), 128'(0));
      chk({tag, "_alast"},  128'(bus.alpha_u_col_tlast), 128'(0));
      chk({tag, "_hrow"},   128'(bus.H_row), 128'(0));
      chk({tag, "_alpha"},  128'(bus.alpha_u_col), 128'(0));
   endtask

   function automatic void build_expected();
      int last;
      beat_t e;
      last = -1;
      for (int r = 0; r < I; r++)
         if (!SKIP || h_m[r] != '0) last = r;
      for (int r = 0; r < I; r++) begin
         if (SKIP && h_m[r] == '0) continue;
         for (int b = 0; b < A; b++) begin
            e.h  = h_m[r];
            e.a  = a_m[r*A + b];
            e.hl = (r == last);
            e.al = (b == A-1);
            q.push_back(e);
         end
      end
   endfunction

   // Monitor: every valid cycle must present the head of the queue; accepted beats pop it.
   initial begin
      beat_t e;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (bus.alpha_u_col_tvalid || bus.H_row_tvalid) begin
               vcnt++;
               if (first_vcyc < 0) first_vcyc = cyc;
               chk("tvalid_pair", 128'(bus.H_row_tvalid), 128'(bus.alpha_u_col_tvalid));
               chk("busy_in_frame", 128'(busy), 128'(1));
               if (q.size() == 0) begin
                  chki("extra_beat", 1, 0);
               end else begin
                  e = q[0];
                  chk("h_row",  128'(bus.H_row), 128'(e.h));
                  chk("alpha",  128'(bus.alpha_u_col), 128'(e.a));
                  chk("h_tlast", 128'(bus.H_row_tlast), 128'(e.hl));
                  chk("a_tlast", 128'(bus.alpha_u_col_tlast), 128'(e.al));
                  if (bus.alpha_u_col_tready) begin
                     void'(q.pop_front());
                     acc_cnt++;
                     last_acc_cyc = cyc;
                  end
               end
            end
            if (done) begin
               done_cnt++;
               done_cyc = cyc;
            end
         end
      end
   end

   task automatic run_frame(input int n_exp, input int stall_at, input int stall_len,
                            input bit poke, input int rst_at);
      int stall_left, budget, pk;
      bit rst_done;
      acc_cnt = 0; vcnt = 0; done_cnt = 0;
      first_vcyc = -1; last_acc_cyc = -1; done_cyc = -1;
      stall_left = stall_len; budget = 0; pk = 0; rst_done = 1'b0;
      build_expected();
      @(posedge clk); #1;
      start = 1'b1;
      start_cyc = cyc;
      @(posedge clk); #1;
      while (done_cnt == 0 && budget < 200 && !rst_done) begin
         start = 1'b0;
         cfg_we = 1'b0;
         bus.alpha_u_col_tready = 1'b1;
         if (stall_at >= 0 && acc_cnt == stall_at && stall_left > 0) begin
            bus.alpha_u_col_tready = 1'b0;
            stall_left--;
         end
         if (poke && pk == 0 && acc_cnt == 2) begin
            start = 1'b1; cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = AW'(6); cfg_wdata = '1;
            pk = 1;
         end else if (poke && pk == 1) begin
            cfg_we = 1'b1; cfg_sel = 1'b1; cfg_addr = AW'(12); cfg_wdata = '1;
            pk = 2;
         end
         if (rst_at >= 0 && acc_cnt == rst_at) begin
            #2 rst_n = 1'b0;
            #1 check_idle_zero("midrst");
            rst_done = 1'b1;
         end else begin
            @(posedge clk); #1;
            budget++;
         end
      end
      start = 1'b0;
      cfg_we = 1'b0;
      bus.alpha_u_col_tready = 1'b1;
      if (rst_done) begin
         q.delete();
         @(posedge clk); #1;
         rst_n = 1'b1;
         @(posedge clk); #1;
         chk("post_rst_busy", 128'(busy), 128'(0));
      end else begin
         chki("done_seen", (done_cnt != 0) ? 1 : 0, 1);
         @(posedge clk); #1;
         @(posedge clk); #1;
         chki("done_pulses", done_cnt, 1);
         chk("busy_after", 128'(busy), 128'(0));
         chki("queue_left", q.size(), 0);
         chki("valid_cycles", vcnt, n_exp + stall_len);
         chki("first_beat_lat", first_vcyc - start_cyc, 1);
         chki("contiguous", last_acc_cyc - first_vcyc + 1, vcnt);
         chki("done_lat", done_cyc - last_acc_cyc, 1);
         q.delete();
      end
   endtask

   initial begin
      rst_n = 1'b0; cfg_we = 1'b0; cfg_sel = 1'b0; cfg_addr = '0; cfg_wdata = '0;
      start = 1'b0; bus.alpha_u_col_tready = 1'b1;
      repeat (3) @(posedge clk);
      #1 check_idle_zero("rst");
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("idle_busy", 128'(busy), 128'(0));

      h_m[0] = 14'b01100010100011;
      h_m[1] = 14'h2B1C; h_m[2] = 14'h0F0F; h_m[3] = 14'h3001;
      h_m[4] = 14'h1234; h_m[5] = 14'h2AAA; h_m[6] = 14'h0555;
      for (int k = 0; k < I*A; k++)
         for (int l = 0; l < J; l++)
            a_m[k][l*8 +: 8] = 8'(k*29 + l*7 + 1);
      a_m[0] = {8'h74,8'hCE,8'hB3,8'hE7,8'hBF,8'hCE,8'h16,8'h1B,8'h51,8'h05,8'h33,8'hF9,8'hA6,8'hFF};
      a_m[1] = {8'h8B,8'h32,8'h4D,8'h19,8'h41,8'h32,8'hE9,8'hE5,8'hAE,8'hFB,8'hCD,8'h06,8'h5A,8'h01};
      for (int r = 0; r < I; r++) cfg_write(1'b0, r, {{(J*7){1'b0}}, h_m[r]});
      for (int k = 0; k < I*A; k++) cfg_write(1'b1, k, a_m[k]);

      // Plain frame, tready held high.
      run_frame(14, -1, 0, 1'b0, -1);

      // Out-of-range writes must leave the tables untouched (8 and 16 would alias rows 0).
      cfg_write(1'b0, 7, '1);
      cfg_write(1'b0, 8, '1);
      cfg_write(1'b1, 14, '1);
      cfg_write(1'b1, 16, '1);

      // Backpressure at beat 5 for three cycles.
      run_frame(14, 5, 3, 1'b0, -1);

      // start and cfg writes issued mid-frame are ignored.
      run_frame(14, -1, 0, 1'b1, -1);

      // Reset at beat 7, then a full replay from row 0.
      run_frame(14, -1, 0, 1'b0, 7);
      run_frame(14, -1, 0, 1'b0, -1);

      // Clear rows 2 and 6: they are skipped only in the skip-empty build.
      cfg_write(1'b0, 2, '0);
      cfg_write(1'b0, 6, '0);
      h_m[2] = '0;
      h_m[6] = '0;
      run_frame(SKIP ? 10 : 14, -1, 0, 1'b0, -1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
